// File: rtl/apb_slave_mem.sv
// APB completer backed by a word-addressed register memory, with a fixed
// number of wait states per transfer and pslverr on out-of-range or misaligned addresses.
module apb_slave_mem #(
   parameter int DEPTH       = 16,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        pclk_i,
   input  logic        prst_i,
   input  logic        psel_i,
   input  logic        pen_i,
   input  logic [31:0] paddr_i,
   input  logic        pwrite_i,
   input  logic [31:0] pwdata_i,
   output logic        pready_o,
   output logic [31:0] prdata_o,
   output logic        pslverr_o
);

   // state  | meaning
   // IDLE   | no transfer, outputs zero, waiting for a setup phase
   // ACCESS | setup latched, counting wait states while pen is high
   // DONE   | pready pulse cycle; a new setup here starts back-to-back
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;

   localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   logic [1:0]    state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic          write_q, write_d;
   logic          pready_q, pready_d;
   logic          pslverr_q, pslverr_d;
   logic [31:0]   prdata_q, prdata_d;
   logic [31:0]   mem_q [DEPTH];

   logic          setup;
   logic          addr_err;
   logic          mem_we;
   logic [AW-1:0] idx;

   assign setup    = psel_i && !pen_i;
   assign idx      = addr_q[AW+1:2];
   // Anything above the last word or not word-aligned is rejected.
   assign addr_err = (addr_q[31:AW+2] != '0) || (addr_q[1:0] != 2'b00);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      write_d   = write_q;
      pready_d  = 1'b0;
      pslverr_d = 1'b0;
      prdata_d  = '0;
      mem_we    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (setup) begin
               addr_d  = paddr_i;
               wdata_d = pwdata_i;
               write_d = pwrite_i;
               cnt_d   = WAIT_INIT;
               state_d = ST_ACCESS;
            end
         end

         ST_ACCESS: begin
            if (!psel_i) begin
               state_d = ST_IDLE;
            end else if (pen_i) begin
               if (cnt_q != 4'd0) begin
                  cnt_d = cnt_q - 4'd1;
               end else begin
                  state_d   = ST_DONE;
                  pready_d  = 1'b1;
                  pslverr_d = addr_err;
                  if (write_q) begin
                     mem_we = !addr_err;
                  end else if (!addr_err) begin
                     prdata_d = mem_q[idx];
                  end
               end
            end
         end

         ST_DONE: begin
            if (setup) begin
               addr_d  = paddr_i;
               wdata_d = pwdata_i;
               write_d = pwrite_i;
               cnt_d   = WAIT_INIT;
               state_d = ST_ACCESS;
            end else begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge pclk_i) begin
      if (prst_i) begin
         state_q   <= ST_IDLE;
         cnt_q     <= 4'd0;
         addr_q    <= '0;
         wdata_q   <= '0;
         write_q   <= 1'b0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         prdata_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         write_q   <= write_d;
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
         prdata_q  <= prdata_d;
         if (mem_we) begin
            mem_q[idx] <= wdata_q;
         end
      end
   end

   assign pready_o  = pready_q;
   assign prdata_o  = prdata_q;
   assign pslverr_o = pslverr_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem: bus 0 drives a WAIT_CYCLES=2 instance,
// bus 1 a WAIT_CYCLES=0 instance; both share clock and reset.
module tb_apb_slave_mem;

   logic        clk = 1'b0;
   logic        prst;
   logic [1:0]  psel, pen, pwrite, pready, pslverr;
   logic [31:0] paddr  [2];
   logic [31:0] pwdata [2];
   logic [31:0] prdata [2];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   apb_slave_mem #(.DEPTH(16), .WAIT_CYCLES(2)) dut_w2 (
      .pclk_i(clk), .prst_i(prst), .psel_i(psel[0]), .pen_i(pen[0]),
      .paddr_i(paddr[0]), .pwrite_i(pwrite[0]), .pwdata_i(pwdata[0]),
      .pready_o(pready[0]), .prdata_o(prdata[0]), .pslverr_o(pslverr[0])
   );

   apb_slave_mem #(.DEPTH(16), .WAIT_CYCLES(0)) dut_w0 (
      .pclk_i(clk), .prst_i(prst), .psel_i(psel[1]), .pen_i(pen[1]),
      .paddr_i(paddr[1]), .pwrite_i(pwrite[1]), .pwdata_i(pwdata[1]),
      .pready_o(pready[1]), .prdata_o(prdata[1]), .pslverr_o(pslverr[1])
   );

   typedef struct {
      string       name;
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      bit          exp_err;
   } vec_t;

   vec_t vecs[16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic chk_idle_out(input string name, input int b);
      chk({name, "_pready"}, {31'd0, pready[b]}, 32'd0);
      chk({name, "_pslverr"}, {31'd0, pslverr[b]}, 32'd0);
      chk({name, "_prdata"}, prdata[b], 32'd0);
   endtask

   // One complete transfer; the bus is scrambled after setup so only the
   // latched values can produce the right answer. lat counts edges from E0.
   task automatic xfer(input int b, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input int hold,
                       output logic [31:0] rdata, output logic err, output int lat);
      @(negedge clk);
      psel[b] = 1'b1; pen[b] = 1'b0; pwrite[b] = wr; paddr[b] = addr; pwdata[b] = wdata;
      @(posedge clk);
      lat = 0;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         paddr[b] = ~addr; pwdata[b] = ~wdata; pwrite[b] = ~wr;
         @(posedge clk);
         lat++;
      end
      @(negedge clk);
      pen[b] = 1'b1; paddr[b] = ~addr; pwdata[b] = ~wdata; pwrite[b] = ~wr;
      rdata = '0; err = 1'b0;
      begin : wait_rdy
         for (int k = 0; k < 64; k++) begin
            @(posedge clk); #1;
            lat++;
            if (pready[b]) begin
               rdata = prdata[b];
               err   = pslverr[b];
               disable wait_rdy;
            end
         end
         lat = -1;
      end
      @(negedge clk);
      psel[b] = 1'b0; pen[b] = 1'b0;
      @(posedge clk); #1;
      chk_idle_out("pulse_end", b);
   endtask

   logic [31:0] rd;
   logic        er;
   int          lat;
   bit          seen;

   initial begin
      psel = '0; pen = '0; pwrite = '0;
      paddr[0] = '0; paddr[1] = '0; pwdata[0] = '0; pwdata[1] = '0;

      vecs[0]  = '{"rd_rst_08",     1'b0, 32'h08,       32'h0,        32'h0,        1'b0};
      vecs[1]  = '{"rd_rst_3c",     1'b0, 32'h3C,       32'h0,        32'h0,        1'b0};
      vecs[2]  = '{"wr_08",         1'b1, 32'h08,       32'hDEADBEEF, 32'h0,        1'b0};
      vecs[3]  = '{"rd_08",         1'b0, 32'h08,       32'h0,        32'hDEADBEEF, 1'b0};
      vecs[4]  = '{"wr_40_oor",     1'b1, 32'h40,       32'h12345678, 32'h0,        1'b1};
      vecs[5]  = '{"rd_00_alias",   1'b0, 32'h00,       32'h0,        32'h0,        1'b0};
      vecs[6]  = '{"rd_06_misal",   1'b0, 32'h06,       32'h0,        32'h0,        1'b1};
      vecs[7]  = '{"wr_04",         1'b1, 32'h04,       32'h11111111, 32'h0,        1'b0};
      vecs[8]  = '{"rd_04",         1'b0, 32'h04,       32'h0,        32'h11111111, 1'b0};
      vecs[9]  = '{"wr_0a_misal",   1'b1, 32'h0A,       32'hAAAA5555, 32'h0,        1'b1};
      vecs[10] = '{"rd_08_keep",    1'b0, 32'h08,       32'h0,        32'hDEADBEEF, 1'b0};
      vecs[11] = '{"rd_41_both",    1'b0, 32'h41,       32'h0,        32'h0,        1'b1};
      vecs[12] = '{"rd_top_oor",    1'b0, 32'hFFFFFFFC, 32'h0,        32'h0,        1'b1};
      vecs[13] = '{"wr_3c",         1'b1, 32'h3C,       32'hCAFEF00D, 32'h0,        1'b0};
      vecs[14] = '{"rd_3c",         1'b0, 32'h3C,       32'h0,        32'hCAFEF00D, 1'b0};
      vecs[15] = '{"rd_40_oor",     1'b0, 32'h40,       32'h0,        32'h0,        1'b1};

      prst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_idle_out("rst_w2", 0);
      chk_idle_out("rst_w0", 1);
      @(negedge clk);
      prst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_idle_out("idle_w2", 0);

      for (int i = 0; i < 16; i++) begin
         xfer(0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, 0, rd, er, lat);
         chk({vecs[i].name, "_lat"}, 32'(lat), 32'd3);
         chk({vecs[i].name, "_prdata"}, rd, vecs[i].exp_rdata);
         chk({vecs[i].name, "_pslverr"}, {31'd0, er}, {31'd0, vecs[i].exp_err});
      end

      // pen held low for two extra cycles in ACCESS stretches the transfer.
      xfer(0, 1'b0, 32'h08, 32'h0, 2, rd, er, lat);
      chk("stretch_lat", 32'(lat), 32'd5);
      chk("stretch_prdata", rd, 32'hDEADBEEF);

      // Abort: psel drops mid-ACCESS of a write to 0x04.
      @(negedge clk);
      psel[0] = 1'b1; pen[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 32'h04; pwdata[0] = 32'h22222222;
      @(posedge clk);
      @(negedge clk);
      pen[0] = 1'b1;
      seen = 1'b0;
      @(posedge clk); #1;
      seen |= pready[0];
      @(negedge clk);
      psel[0] = 1'b0; pen[0] = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
         seen |= pready[0];
      end
      chk("abort_no_pready", {31'd0, seen}, 32'd0);
      xfer(0, 1'b0, 32'h04, 32'h0, 0, rd, er, lat);
      chk("abort_word_kept", rd, 32'h11111111);

      // pen without a setup phase is ignored.
      @(negedge clk);
      psel[0] = 1'b1; pen[0] = 1'b1; pwrite[0] = 1'b0; paddr[0] = 32'h08;
      seen = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
         seen |= pready[0];
      end
      chk("nosetup_no_pready", {31'd0, seen}, 32'd0);
      @(negedge clk);
      psel[0] = 1'b0; pen[0] = 1'b0;

      // Zero wait states: back-to-back writes to 0x00 and 0x3C.
      @(negedge clk);
      psel[1] = 1'b1; pen[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 32'h00; pwdata[1] = 32'hA1A1A1A1;
      @(posedge clk);
      @(negedge clk);
      pen[1] = 1'b1; paddr[1] = 32'h3C; pwdata[1] = 32'h0;
      @(posedge clk); #1;
      chk("b2b_first_pready", {31'd0, pready[1]}, 32'd1);
      chk("b2b_first_err", {31'd0, pslverr[1]}, 32'd0);
      @(negedge clk);
      pen[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 32'h3C; pwdata[1] = 32'hB2B2B2B2;
      @(posedge clk); #1;
      chk("b2b_gap_pready", {31'd0, pready[1]}, 32'd0);
      @(negedge clk);
      pen[1] = 1'b1; paddr[1] = 32'h00; pwdata[1] = 32'h0;
      @(posedge clk); #1;
      chk("b2b_second_pready", {31'd0, pready[1]}, 32'd1);
      @(negedge clk);
      psel[1] = 1'b0; pen[1] = 1'b0;
      @(posedge clk); #1;
      chk_idle_out("b2b_end", 1);
      xfer(1, 1'b0, 32'h00, 32'h0, 0, rd, er, lat);
      chk("w0_rd_00_lat", 32'(lat), 32'd1);
      chk("w0_rd_00", rd, 32'hA1A1A1A1);
      xfer(1, 1'b0, 32'h3C, 32'h0, 0, rd, er, lat);
      chk("w0_rd_3c", rd, 32'hB2B2B2B2);
      chk("w0_rd_3c_err", {31'd0, er}, 32'd0);
      xfer(1, 1'b0, 32'h06, 32'h0, 0, rd, er, lat);
      chk("w0_rd_06_err", {31'd0, er}, 32'd1);

      // Reset during ACCESS of a write to 0x10.
      @(negedge clk);
      psel[0] = 1'b1; pen[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 32'h10; pwdata[0] = 32'h55AA55AA;
      @(posedge clk);
      @(negedge clk);
      pen[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      prst = 1'b1;
      seen = 1'b0;
      @(posedge clk); #1;
      chk_idle_out("rstmid", 0);
      @(negedge clk);
      psel[0] = 1'b0; pen[0] = 1'b0; prst = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
         seen |= pready[0];
      end
      chk("rstmid_no_pready", {31'd0, seen}, 32'd0);
      xfer(0, 1'b0, 32'h10, 32'h0, 0, rd, er, lat);
      chk("rstmid_word_zero", rd, 32'h0);
      xfer(0, 1'b0, 32'h08, 32'h0, 0, rd, er, lat);
      chk("rstmid_mem_cleared", rd, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/apb_slave_mem.md
# apb_slave_mem

APB completer that terminates the bus driven by the team's APB master: it consumes psel/pen/paddr/pwrite/pwdata and returns pready/prdata/pslverr. It backs a small word-addressed register memory, inserts a parameterised number of wait states per transfer, and flags out-of-range or misaligned accesses with pslverr. It is the target stage that the APB master feeds, in both block tests and the UVM environment.

## Interface
- DEPTH, 16: number of 32-bit words; power of two, 2..256.
- WAIT_CYCLES, 2: wait states inserted in every transfer, 0..15.

- pclk  in  1  clock, all logic on rising edge
- prst  in  1  reset, synchronous, active-high
- psel  in  1  slave select from master
- pen  in  1  enable (access phase) from master
- paddr  in  32  byte address
- pwrite  in  1  1 = write, 0 = read
- pwdata  in  32  write data
- pready  out  1  transfer complete, one-cycle pulse
- prdata  out  32  read data, valid only while pready=1
- pslverr  out  1  error response, valid only while pready=1

## Operation
- Reset (prst=1 at an edge): state→IDLE, counter→0, pready=0, prdata=0, pslverr=0, all DEPTH words→0. Reset takes priority over every other event and aborts any transfer without a memory write.
- Address decode: index = paddr[2+log2(DEPTH)-1:2]. Error when paddr ≥ 4·DEPTH or paddr[1:0]≠0.
- States:
  - IDLE: outputs zero. At an edge with psel=1, pen=0 (setup): latch paddr, pwrite, pwdata; counter←WAIT_CYCLES; go ACCESS. pen=1 without a prior setup is ignored (stay IDLE).
  - ACCESS: at an edge with psel=0: abort, go IDLE, no write. With psel=1, pen=0: hold. With psel=1, pen=1, counter≠0: counter−1. With psel=1, pen=1, counter=0: complete, go DONE.
  - Completion edge: write: if no error, mem[index]←latched pwdata; prdata←0. Read: prdata←mem[index] (0 on error). pslverr←error; pready←1.
  - DONE: pready=1 for exactly one cycle. Next edge: pready, pslverr and prdata return to 0. If that edge also sees psel=1, pen=0, latch the new setup and go ACCESS (back-to-back). Otherwise go IDLE.
- Errored writes never modify memory. Latched (setup-phase) address, data and direction are used, so changes on the bus during ACCESS have no effect.
- Read-after-write to the same word in the next transfer returns the new value.

## Timing
- Let E0 be the edge that samples setup. If pen=1 is held from E0+1 onward, pready is high during the cycle after edge E0+WAIT_CYCLES+1.
  - WAIT_CYCLES=0: pready high in the cycle after E0+1, i.e. zero wait states.
  - WAIT_CYCLES=2: pready high after E0+3.
- Each cycle with pen=0 in ACCESS delays completion by one cycle.
- The memory write commits on the same edge that raises pready.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Maximum throughput: one transfer every WAIT_CYCLES+2 cycles.

## Test plan
- Reset then idle: hold prst=1 for 2 cycles, then psel=0. pready, prdata and pslverr stay 0; a read of any valid word returns 0.
- Write/read, WAIT_CYCLES=2: write 0xDEADBEEF to 0x08, then read 0x08.
  - pready is high exactly after E0+3 in each transfer.
  - Read returns prdata=0xDEADBEEF with pslverr=0.
- Zero wait, WAIT_CYCLES=0: back-to-back writes to 0x00 and 0x3C, then reads of both.
  - Each transfer takes 2 cycles.
  - Reads return the correct data.
- Errors:
  - Write 0x12345678 to 0x40 (DEPTH=16): pslverr=1 with pready; memory is unchanged.
  - Read 0x06: pslverr=1, prdata=0.
- Abort and protocol: drop psel mid-ACCESS during a write to 0x04 (word was 0x11111111): no pready, word still 0x11111111. pen=1 without a setup phase: no response.
- Reset mid-op: assert prst during ACCESS of a write. Outputs go to 0 on the next edge, no pready is ever issued, and the target word reads back 0.
